// File: rtl/ova_pkg.sv
// ova_pkg: shared types and default geometry for the OV camera capture path.
//   state_t       - capture sequencer states
//   OVA_*         - default frame geometry and settling-frame count
package ova_pkg;

  typedef enum logic [2:0] {
    S_SKIP    = 3'd0,
    S_IDLE    = 3'd1,
    S_WAIT_VS = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int unsigned OVA_H_PIX       = 640;
  localparam int unsigned OVA_V_LINES     = 480;
  localparam int unsigned OVA_SKIP_FRAMES = 10;

endpackage

// File: rtl/ova_edge_det.sv
// ova_edge_det: 1-bit edge detector. The input is registered once and the
// live input is compared against that copy, so an edge is flagged in the
// same cycle the input changes.
//   clk, rst - clock, synchronous active-high reset
//   d        - input level
//   rise     - d is 1 now, was 0 last cycle
//   fall     - d is 0 now, was 1 last cycle
module ova_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;
  logic d_d;

  assign d_d = d;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/ova_frame_ctrl.sv
// ova_frame_ctrl: frame-level capture sequencer between the byte-pairing
// camera reader and the pixel FIFO. Discards settling frames after reset,
// then captures vsync-aligned frames on request (single-shot or continuous),
// gating FIFO writes and checking frame geometry.
//   i_pclk, rst        - pixel clock, synchronous active-high reset
//   vsync, href        - camera sync (i_pclk domain)
//   i_pix_data/_vld    - 16-bit pixel and strobe from the reader
//   i_fifo_full        - FIFO back-pressure (pixels are dropped, not stalled)
//   i_cap_req/_cont    - capture request, continuous-mode select
//   o_fifo_wr_en/_data - registered FIFO write port
//   o_ready, o_busy    - IDLE / WAIT_VS-or-CAPTURE status
//   o_frame_start/done - single-cycle frame pulses
//   o_err_ovf/_size    - sticky overflow / geometry errors
//   o_line_cnt         - lines completed in the current or last frame
module ova_frame_ctrl
  import ova_pkg::*;
#(
  parameter int unsigned H_PIX       = OVA_H_PIX,
  parameter int unsigned V_LINES     = OVA_V_LINES,
  parameter int unsigned SKIP_FRAMES = OVA_SKIP_FRAMES,
  parameter int unsigned PCW         = 11,
  parameter int unsigned LCW         = 10
) (
  input  logic           i_pclk,
  input  logic           rst,
  input  logic           vsync,
  input  logic           href,
  input  logic [15:0]    i_pix_data,
  input  logic           i_pix_vld,
  input  logic           i_fifo_full,
  input  logic           i_cap_req,
  input  logic           i_cap_cont,
  output logic           o_fifo_wr_en,
  output logic [15:0]    o_fifo_wr_data,
  output logic           o_ready,
  output logic           o_busy,
  output logic           o_frame_start,
  output logic           o_frame_done,
  output logic           o_err_ovf,
  output logic           o_err_size,
  output logic [LCW-1:0] o_line_cnt
);

  localparam int unsigned SCW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SCW-1:0] SKIP_TGT = SCW'(SKIP_FRAMES);
  localparam logic [PCW-1:0] H_PIX_C  = PCW'(H_PIX);
  localparam logic [LCW-1:0] V_LINE_C = LCW'(V_LINES);

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  ova_edge_det u_vs_edge (
    .clk  (i_pclk),
    .rst  (rst),
    .d    (vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  ova_edge_det u_hr_edge (
    .clk  (i_pclk),
    .rst  (rst),
    .d    (href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  state_t          state_q, state_d;
  logic [SCW-1:0]  skip_cnt_q, skip_cnt_d;
  logic            cont_q, cont_d;
  logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LCW-1:0]  line_cnt_q, line_cnt_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_size_q, err_size_d;
  logic            wr_en_q, wr_en_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;

  logic [SCW-1:0]  skip_next;
  logic [PCW-1:0]  pix_sat;
  logic [PCW-1:0]  pix_now;
  logic [LCW-1:0]  line_sat;
  logic [LCW-1:0]  line_now;

  assign skip_next = skip_cnt_q + SCW'(vs_rise);
  assign pix_sat   = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + PCW'(1);
  assign line_sat  = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + LCW'(1);

  // Pixel count including this cycle's strobe; a line start restarts the
  // count so a partial line seen before capture cannot leak into the next.
  always_comb begin
    pix_now = pix_cnt_q;
    if (hr_rise)        pix_now = PCW'(i_pix_vld);
    else if (i_pix_vld) pix_now = pix_sat;
  end

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    cont_d        = cont_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    err_ovf_d     = err_ovf_q;
    err_size_d    = err_size_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_now      = line_cnt_q;

    unique case (state_q)
      S_SKIP: begin
        skip_cnt_d = skip_next;
        if (skip_next >= SKIP_TGT) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (i_cap_req) begin
          cont_d     = i_cap_cont;
          err_ovf_d  = 1'b0;
          err_size_d = 1'b0;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          state_d    = S_WAIT_VS;
        end
      end

      S_WAIT_VS: begin
        if (vs_fall) begin
          pix_cnt_d     = '0;
          frame_start_d = 1'b1;
          state_d       = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (i_pix_vld) begin
          if (!i_fifo_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_pix_data;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        pix_cnt_d = pix_now;

        // Line is closed before the frame-end check so a coincident
        // href fall is counted toward the frame's line total.
        if (hr_fall) begin
          if (pix_now != H_PIX_C) err_size_d = 1'b1;
          line_now  = line_sat;
          pix_cnt_d = '0;
        end
        line_cnt_d = line_now;

        if (vs_rise) begin
          if (line_now != V_LINE_C) err_size_d = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        if (cont_q && i_cap_cont) begin
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          state_d    = S_WAIT_VS;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (rst) begin
      state_q       <= S_SKIP;
      skip_cnt_q    <= '0;
      cont_q        <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      err_ovf_q     <= 1'b0;
      err_size_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      cont_q        <= cont_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      err_ovf_q     <= err_ovf_d;
      err_size_q    <= err_size_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign o_fifo_wr_en   = wr_en_q;
  assign o_fifo_wr_data = wr_data_q;
  assign o_ready        = (state_q == S_IDLE);
  assign o_busy         = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign o_frame_start  = frame_start_q;
  assign o_frame_done   = frame_done_q;
  assign o_err_ovf      = err_ovf_q;
  assign o_err_size     = err_size_q;
  assign o_line_cnt     = line_cnt_q;

endmodule

// File: doc/ova_frame_ctrl.md
Name: ova_frame_ctrl

Overview:
- Frame-level capture sequencer for the OV camera path.
- Sits between the byte-pairing camera reader, which supplies 16-bit pixels plus a valid strobe, and the pixel FIFO.
- Drops the settling frames after reset, then captures frames on request (single-shot or continuous) aligned to vsync.
- Gates FIFO writes, counts pixels and lines, and flags overflow and frame-size errors.

Parameters:
- H_PIX, 640, 16-bit pixels expected per line (per href high period).
- V_LINES, 480, lines expected per frame.
- SKIP_FRAMES, 10, complete frames discarded after reset before o_ready asserts; 0 allowed.
- PCW, 11, pixel counter width (must hold H_PIX).
- LCW, 10, line counter width (must hold V_LINES).

Ports:
- i_pclk  in  1  camera pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vsync  in  1  camera vsync, high between frames; already in i_pclk domain.
- href  in  1  camera href, high during active line.
- i_pix_data  in  16  pixel from reader.
- i_pix_vld  in  1  pixel strobe from reader (every other cycle during href).
- i_fifo_full  in  1  pixel FIFO full.
- i_cap_req  in  1  1-cycle capture request.
- i_cap_cont  in  1  continuous mode; sampled with i_cap_req, re-checked at each frame end.
- o_fifo_wr_en  out  1  FIFO write strobe.
- o_fifo_wr_data  out  16  FIFO write data.
- o_ready  out  1  skip done and FSM in IDLE; requests are accepted only when high.
- o_busy  out  1  FSM in WAIT_VS or CAPTURE.
- o_frame_start  out  1  1-cycle pulse at the first capture cycle.
- o_frame_done  out  1  1-cycle pulse at frame end.
- o_err_ovf  out  1  sticky: a pixel was dropped because the FIFO was full.
- o_err_size  out  1  sticky: pixel or line count mismatch.
- o_line_cnt  out  LCW  lines completed in the current or last frame.

Behaviour:
- Reset: every output is 0, the FSM goes to SKIP, all counters are 0, and the edge-detect registers are 0. Reset mid-frame aborts the frame with no done pulse.
- Edge detection: vsync and href are registered once. An edge is the current value against the registered value, so events are seen in the same cycle the input changes.
- States: SKIP, IDLE, WAIT_VS, CAPTURE, DONE (encoding in package).
- SKIP:
  - Counts vsync rising edges.
  - When the count reaches SKIP_FRAMES, go to IDLE; with SKIP_FRAMES=0, go to IDLE the cycle after reset.
  - i_cap_req is ignored here.
- IDLE:
  - o_ready=1.
  - When i_cap_req=1, latch cont=i_cap_cont, clear o_err_ovf, o_err_size and o_line_cnt, then go to WAIT_VS.
- WAIT_VS:
  - Waits for a vsync falling edge. A request made mid-frame therefore never captures a partial frame.
  - On the edge: go to CAPTURE and pulse o_frame_start in the next cycle (first CAPTURE cycle).
- CAPTURE pixel path:
  - When i_pix_vld=1 and i_fifo_full=0: next cycle o_fifo_wr_en=1 and o_fifo_wr_data=i_pix_data (1-cycle registered latency).
  - When i_pix_vld=1 and i_fifo_full=1: the pixel is dropped, o_err_ovf is set, and the pixel counter still increments.
- CAPTURE line accounting (href falling edge):
  - If the pixel count differs from H_PIX, set o_err_size.
  - Increment o_line_cnt (saturating at its maximum) and clear the pixel counter.
- CAPTURE frame end (vsync rising edge):
  - If o_line_cnt differs from V_LINES, set o_err_size.
  - Go to DONE.
- CAPTURE precedence: if href falls in the same cycle vsync rises, the line is accounted first, then the frame end is taken.
- DONE (one cycle):
  - Pulse o_frame_done.
  - If cont=1 and i_cap_cont=1 this cycle, clear the counters (errors stay sticky) and go to WAIT_VS.
  - Otherwise go to IDLE.
- i_cap_req while busy: ignored.
- Deasserting i_cap_cont mid-frame finishes the current frame, then returns to IDLE.
- Writes occur only in CAPTURE. No write is issued in any other state, even if i_pix_vld=1.

Decomposition:
- Shared package ova_pkg:
  - State enum localparams (S_SKIP, S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE).
  - Default frame geometry constants (OVA_H_PIX=640, OVA_V_LINES=480, OVA_SKIP_FRAMES=10).
- Sub-module ova_edge_det: 1-bit registered edge detector with rise/fall outputs. It is instantiated twice, for vsync and for href.

Test Plan:
- SKIP_FRAMES=2, H_PIX=4, V_LINES=3: after reset send 2 vsync pulses -> o_ready=0 until the second vsync rising edge, then 1. An i_cap_req during skip leaves o_busy=0.
- Single capture, 3 lines × 4 pixels, FIFO never full -> exactly 12 o_fifo_wr_en pulses with data matching the sequence in order, one o_frame_start, one o_frame_done, o_line_cnt=3, no errors, back in IDLE.
- Request mid-frame (vsync low, lines active) -> zero writes until the next vsync falling edge. The following frame is captured completely (12 writes).
- i_fifo_full high for pixel 5 -> 11 writes, o_err_ovf=1 after the frame, o_err_size=0. The next i_cap_req clears o_err_ovf.
- Frame with 3 pixels on line 2 and only 2 lines -> o_err_size=1 at frame end, o_frame_done still pulses.
- Continuous mode over 3 frames, i_cap_cont dropped during frame 2 -> 2 o_frame_done pulses (frames 1 and 2), then IDLE. Frame 3 produces no writes. Reset asserted mid-frame 1 of a repeat run -> all outputs 0 and FSM in SKIP.
